// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access router: FSM states, access classes
// and width helpers used by the router and its region decoder.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } routerStateT;

    typedef enum logic [1:0] {
        ACC_NONE   = 2'd0,
        ACC_PERIPH = 2'd1,
        ACC_MEM    = 2'd2
    } accessTypeT;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wait counter is never narrower than 8 bits.
    function automatic int cntWidth(input int t);
        return (t > 255) ? $clog2(t + 1) : 8;
    endfunction

endpackage

// File: rtl/addr_region_decoder.sv
// Combinational address-region decoder: per-channel hit vector, lowest-index
// one-hot winner and its binary index.
module addr_region_decoder
    import mem_ctrl_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter logic [NCH*ADDR_W-1:0] REGION_BASE  = {32'h20000, 32'h10000},
    parameter logic [NCH*ADDR_W-1:0] REGION_LIMIT = {32'h2FFFF, 32'h1FFFF},
    parameter int IDX_W  = idxWidth(NCH)
) (
    input  logic              En,
    input  logic [ADDR_W-1:0] Address,
    output logic [NCH-1:0]    Hit,
    output logic [NCH-1:0]    HitOneHot,
    output logic [IDX_W-1:0]  HitIdx
);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : gen_region
            logic [ADDR_W-1:0] regionBase;
            logic [ADDR_W-1:0] regionLimit;
            assign regionBase  = REGION_BASE[gi*ADDR_W +: ADDR_W];
            assign regionLimit = REGION_LIMIT[gi*ADDR_W +: ADDR_W];
            assign Hit[gi] = En && (Address >= regionBase) && (Address <= regionLimit);
        end
    endgenerate

    // Isolate the lowest set bit so overlapping regions favour the lowest channel.
    assign HitOneHot = Hit & (~Hit + NCH'(1));

    always_comb begin
        HitIdx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (HitOneHot[i]) begin
                HitIdx = HitIdx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_access_router.sv
// Routes CPU requests either straight through to the cache or, for decoded
// peripheral regions, through a start/wait/complete handshake with timeout.
module mem_access_router
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NCH    = 2,
    parameter logic [NCH*ADDR_W-1:0] REGION_BASE  = {32'h20000, 32'h10000},
    parameter logic [NCH*ADDR_W-1:0] REGION_LIMIT = {32'h2FFFF, 32'h1FFFF},
    parameter int TIMEOUT = 255
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  En,
    input  logic                  RW,
    input  logic [ADDR_W-1:0]     Address,
    input  logic [DATA_W-1:0]     IData,
    output logic                  Stall,
    output logic [DATA_W-1:0]     OData,
    output logic                  BusErr,
    output logic [NCH-1:0]        P_Start,
    output logic                  P_RW,
    output logic [ADDR_W-1:0]     P_Addr,
    output logic [DATA_W-1:0]     P_WData,
    input  logic [NCH-1:0]        P_Done,
    input  logic [NCH*DATA_W-1:0] P_RData,
    output logic                  C_En,
    output logic                  C_RW,
    output logic [ADDR_W-1:0]     C_Address,
    output logic [DATA_W-1:0]     C_WriteData,
    input  logic [DATA_W-1:0]     C_ReadData,
    input  logic                  C_Stall,
    input  logic [DATA_W-1:0]     LB_CriticalWord,
    input  logic                  RWordSelect
);

    localparam int IDX_W = idxWidth(NCH);
    localparam int CNT_W = cntWidth(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    routerStateT        stateReg;
    logic [IDX_W-1:0]   chReg;
    logic               rwReg;
    logic [ADDR_W-1:0]  addrReg;
    logic [DATA_W-1:0]  wdataReg;
    logic [DATA_W-1:0]  rdataReg;
    logic [CNT_W-1:0]   cntReg;
    logic [NCH-1:0]     pStartReg;

    logic               reqEn;
    logic [NCH-1:0]     hitVec;
    logic [NCH-1:0]     hitOneHot;
    logic [IDX_W-1:0]   hitIdx;
    accessTypeT         accessType;
    logic               chDone;
    logic [DATA_W-1:0]  chRData;

    // Requests are masked while reset is held so every output reads zero.
    assign reqEn = En & Rst_n;

    addr_region_decoder #(
        .NCH          (NCH),
        .ADDR_W       (ADDR_W),
        .REGION_BASE  (REGION_BASE),
        .REGION_LIMIT (REGION_LIMIT),
        .IDX_W        (IDX_W)
    ) u_decoder (
        .En        (reqEn),
        .Address   (Address),
        .Hit       (hitVec),
        .HitOneHot (hitOneHot),
        .HitIdx    (hitIdx)
    );

    always_comb begin
        accessType = ACC_NONE;
        if (stateReg == ST_IDLE && reqEn) begin
            accessType = (|hitVec) ? ACC_PERIPH : ACC_MEM;
        end
    end

    assign chDone  = P_Done[chReg];
    assign chRData = P_RData[chReg*DATA_W +: DATA_W];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateReg  <= ST_IDLE;
            chReg     <= '0;
            rwReg     <= 1'b0;
            addrReg   <= '0;
            wdataReg  <= '0;
            rdataReg  <= '0;
            cntReg    <= '0;
            pStartReg <= '0;
        end else begin
            pStartReg <= '0;
            case (stateReg)
                ST_IDLE: begin
                    if (accessType == ACC_PERIPH) begin
                        chReg     <= hitIdx;
                        rwReg     <= RW;
                        addrReg   <= Address;
                        wdataReg  <= IData;
                        rdataReg  <= '0;
                        cntReg    <= '0;
                        pStartReg <= hitOneHot;
                        stateReg  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cntReg <= '0;
                    if (chDone) begin
                        if (!rwReg) begin
                            rdataReg <= chRData;
                        end
                        stateReg <= ST_DONE;
                    end else begin
                        stateReg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion in the final wait cycle still wins over the timeout.
                    if (chDone) begin
                        if (!rwReg) begin
                            rdataReg <= chRData;
                        end
                        stateReg <= ST_DONE;
                    end else if (cntReg == CNT_LAST) begin
                        stateReg <= ST_ERR;
                    end else begin
                        cntReg <= cntReg + 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    stateReg <= ST_IDLE;
                end
                default: begin
                    stateReg <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Stall       = 1'b0;
        OData       = '0;
        BusErr      = 1'b0;
        C_En        = 1'b0;
        C_RW        = 1'b0;
        C_Address   = '0;
        C_WriteData = '0;
        case (stateReg)
            ST_IDLE: begin
                if (accessType == ACC_PERIPH) begin
                    Stall = 1'b1;
                end else if (accessType == ACC_MEM) begin
                    C_En        = 1'b1;
                    C_RW        = RW;
                    C_Address   = Address;
                    C_WriteData = IData;
                    Stall       = C_Stall;
                    OData       = RWordSelect ? LB_CriticalWord : C_ReadData;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                Stall = 1'b1;
            end
            ST_DONE: begin
                OData = rwReg ? '0 : rdataReg;
            end
            ST_ERR: begin
                BusErr = 1'b1;
            end
            default: begin
                Stall = 1'b0;
            end
        endcase
    end

    assign P_Start = pStartReg;
    assign P_RW    = rwReg;
    assign P_Addr  = addrReg;
    assign P_WData = wdataReg;

endmodule

// File: tb/tb_mem_access_router.sv
// Self-checking bench for mem_access_router: transaction-level reference model
// checked every cycle, directed boundary scenarios, then randomized traffic.
module tb_mem_access_router;

    localparam int TO = 255;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        En, RW;
    logic [31:0] Address, IData;
    logic        Stall;
    logic [31:0] OData;
    logic        BusErr;
    logic [1:0]  P_Start;
    logic        P_RW;
    logic [31:0] P_Addr, P_WData;
    logic [1:0]  P_Done;
    logic [63:0] P_RData;
    logic        C_En, C_RW;
    logic [31:0] C_Address, C_WriteData, C_ReadData;
    logic        C_Stall;
    logic [31:0] LB_CriticalWord;
    logic        RWordSelect;

    mem_access_router dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .En              (En),
        .RW              (RW),
        .Address         (Address),
        .IData           (IData),
        .Stall           (Stall),
        .OData           (OData),
        .BusErr          (BusErr),
        .P_Start         (P_Start),
        .P_RW            (P_RW),
        .P_Addr          (P_Addr),
        .P_WData         (P_WData),
        .P_Done          (P_Done),
        .P_RData         (P_RData),
        .C_En            (C_En),
        .C_RW            (C_RW),
        .C_Address       (C_Address),
        .C_WriteData     (C_WriteData),
        .C_ReadData      (C_ReadData),
        .C_Stall         (C_Stall),
        .LB_CriticalWord (LB_CriticalWord),
        .RWordSelect     (RWordSelect)
    );

    always #5 Clk = ~Clk;

    // Stimulus staged here and applied just after each rising edge.
    logic        sRstN, sEn, sRW, sCStall, sSel;
    logic [31:0] sAddr, sIData, sCRData, sLB, sRData0, sRData1;
    logic [1:0]  sDone;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nTxn  = 0;

    // Reference model: one outstanding peripheral transaction at most.
    bit          mBusy = 0;
    int          mIssue, mRes, mCh, mDelay;
    bit          mWr, mErr;
    logic [31:0] mAddr, mWData, mRData;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int regionOf(input logic [31:0] a);
        if (a >= 32'h10000 && a <= 32'h1FFFF) return 0;
        if (a >= 32'h20000 && a <= 32'h2FFFF) return 1;
        return -1;
    endfunction

    task automatic applyStim();
        Rst_n           = sRstN;
        En              = sEn;
        RW              = sRW;
        Address         = sAddr;
        IData           = sIData;
        P_Done          = sDone;
        P_RData         = {sRData1, sRData0};
        C_ReadData      = sCRData;
        C_Stall         = sCStall;
        LB_CriticalWord = sLB;
        RWordSelect     = sSel;
    endtask

    task automatic idleStim();
        sEn = 0; sRW = 0; sAddr = 0; sIData = 0; sDone = 0;
        sCStall = 0; sCRData = 0; sLB = 0; sSel = 0; sRData0 = 0; sRData1 = 0;
    endtask

    task automatic modelCompare();
        logic        eStall, eBusErr, eCEn;
        logic [31:0] eOData;
        logic [1:0]  ePStart;
        bit          issueNow;
        int          k;
        eStall = 0; eBusErr = 0; eCEn = 0; eOData = 0; ePStart = 0; issueNow = 0;
        if (Rst_n !== 1'b1) begin
            mBusy = 0;
        end else if (!mBusy) begin
            k = En ? regionOf(Address) : -1;
            if (k >= 0) begin
                eStall = 1;
                mBusy  = 1;
                mIssue = cyc + 1;
                mRes   = -1;
                mCh    = k;
                mWr    = RW;
                mAddr  = Address;
                mWData = IData;
                mDelay = ($urandom_range(39) == 0) ? 1000 : int'($urandom_range(8));
            end else if (En) begin
                eCEn   = 1;
                eStall = C_Stall;
                eOData = RWordSelect ? LB_CriticalWord : C_ReadData;
            end
        end else if (cyc == mRes) begin
            if (mErr) eBusErr = 1;
            else      eOData  = mRData;
            mBusy = 0;
            nTxn++;
            $display("txn %0d: ch%0d %s addr=%h -> %s data=%h", nTxn, mCh,
                     mWr ? "WR" : "RD", mAddr, mErr ? "buserr" : "ok", eOData);
        end else begin
            eStall = 1;
            if (cyc == mIssue) begin
                ePStart  = (mCh == 0) ? 2'b01 : 2'b10;
                issueNow = 1;
            end
            if (P_Done[mCh]) begin
                mRes   = cyc + 1;
                mErr   = 0;
                mRData = mWr ? 32'h0 : P_RData[mCh*32 +: 32];
            end else if (cyc == mIssue + TO) begin
                mRes = cyc + 1;
                mErr = 1;
            end
        end
        chk("stall", Stall, eStall);
        chk("odata", OData, eOData);
        chk("buserr", BusErr, eBusErr);
        chk("p_start", P_Start, ePStart);
        chk("c_en", C_En, eCEn);
        if (eCEn) begin
            chk("c_rw", C_RW, RW);
            chk("c_addr", C_Address, Address);
            chk("c_wdata", C_WriteData, IData);
        end
        if (issueNow) begin
            chk("p_addr", P_Addr, mAddr);
            chk("p_wdata", P_WData, mWData);
            chk("p_rw", P_RW, mWr);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1 applyStim();
        #1 modelCompare();
        cyc++;
    endtask

    function automatic logic [31:0] pickAddr();
        case ($urandom_range(9))
            0: return 32'h10000 + $urandom_range(32'hFFFF);
            1: return 32'h20000 + $urandom_range(32'hFFFF);
            2: return 32'h0FFFF;
            3: return 32'h10000;
            4: return 32'h1FFFF;
            5: return 32'h20000;
            6: return 32'h2FFFF;
            7: return 32'h30000;
            default: return $urandom;
        endcase
    endfunction

    task automatic genRandom();
        sEn     = ($urandom_range(3) != 0);
        sRW     = 1'($urandom_range(1));
        sAddr   = pickAddr();
        sIData  = $urandom;
        sCStall = 1'($urandom_range(1));
        sCRData = $urandom;
        sLB     = $urandom;
        sSel    = 1'($urandom_range(1));
        sRData0 = $urandom;
        sRData1 = $urandom;
        sDone   = 2'($urandom_range(3));
        if (mBusy && mRes < 0) begin
            sDone[mCh] = (cyc == mIssue + mDelay);
        end
    endtask

    initial begin
        int found;
        sRstN = 0;
        idleStim();
        applyStim();
        #2;
        chk("rst_stall", Stall, 0);
        chk("rst_odata", OData, 0);
        chk("rst_buserr", BusErr, 0);
        chk("rst_pstart", P_Start, 0);
        chk("rst_cen", C_En, 0);
        step(); step();
        sRstN = 1;
        step(); step();

        // Cache read with two stall cycles, then the critical-word bypass.
        sEn = 1; sAddr = 32'h400; sCRData = 32'hCAFE; sCStall = 1;
        step(); chk("cache_stall1", Stall, 1); chk("cache_nostart1", P_Start, 0);
        step(); chk("cache_stall2", Stall, 1);
        sCStall = 0;
        step(); chk("cache_stall3", Stall, 0); chk("cache_odata", OData, 32'hCAFE);
        chk("cache_nostart3", P_Start, 0);
        sSel = 1; sLB = 32'hBEEF;
        step(); chk("crit_word", OData, 32'hBEEF);
        idleStim(); step(); chk("idle_odata", OData, 0); chk("idle_stall", Stall, 0);

        // Channel 0 read, completion 3 cycles after the start pulse.
        sEn = 1; sAddr = 32'h10004;
        step(); chk("p0_accept_stall", Stall, 1); chk("p0_accept_cen", C_En, 0);
        idleStim();
        step(); chk("p0_start", P_Start, 2'b01); chk("p0_addr", P_Addr, 32'h10004);
        step(); chk("p0_start_once", P_Start, 0);
        step();
        sDone = 2'b01; sRData0 = 32'h1234;
        step(); chk("p0_wait_stall", Stall, 1);
        idleStim();
        step(); chk("p0_done_odata", OData, 32'h1234); chk("p0_done_stall", Stall, 0);
        step(); chk("p0_after_odata", OData, 0);

        // Channel 1 write, with a stray completion on channel 0.
        sEn = 1; sRW = 1; sAddr = 32'h20010; sIData = 32'hA5A5;
        step();
        idleStim();
        step(); chk("p1_start", P_Start, 2'b10); chk("p1_wdata", P_WData, 32'hA5A5);
        chk("p1_rw", P_RW, 1);
        sDone = 2'b01;
        step(); chk("ignore_wrong_ch", Stall, 1);
        sDone = 2'b10; sRData1 = 32'hFFFF_FFFF;
        step();
        idleStim();
        step(); chk("p1_done_stall", Stall, 0); chk("p1_write_odata", OData, 0);

        // Region boundaries.
        sEn = 1; sAddr = 32'h0FFFF;
        step(); chk("b_0ffff_cache", C_En, 1);
        sAddr = 32'h30000;
        step(); chk("b_30000_cache", C_En, 1); chk("b_30000_addr", C_Address, 32'h30000);
        sAddr = 32'h1FFFF;
        step(); chk("b_1ffff_stall", Stall, 1); chk("b_1ffff_cen", C_En, 0);
        idleStim(); sDone = 2'b01; sRData0 = 32'h55;
        step(); chk("b_1ffff_start", P_Start, 2'b01);
        idleStim();
        step(); chk("issue_done_odata", OData, 32'h55); chk("issue_done_stall", Stall, 0);
        sEn = 1; sAddr = 32'h20000;
        step();
        idleStim();
        step(); chk("b_20000_start", P_Start, 2'b10);
        sDone = 2'b10;
        step();
        idleStim();
        step();

        // Timeout with no completion.
        sEn = 1; sAddr = 32'h10000;
        step();
        idleStim();
        found = -1;
        for (int s = 1; s <= 400; s++) begin
            step();
            if (BusErr === 1'b1) begin
                found = s;
                break;
            end
        end
        chk("timeout_cycles", found - 1, 256);
        chk("err_odata", OData, 0);
        chk("err_stall", Stall, 0);
        step(); chk("err_one_cycle", BusErr, 0);

        // Asynchronous reset during a wait, then a late completion.
        sEn = 1; sAddr = 32'h1FFFF;
        step();
        idleStim();
        step(); step(); step();
        #2;
        sRstN = 0; Rst_n = 0; En = 0; mBusy = 0;
        #1;
        chk("arst_stall", Stall, 0);
        chk("arst_odata", OData, 0);
        chk("arst_buserr", BusErr, 0);
        chk("arst_pstart", P_Start, 0);
        chk("arst_paddr", P_Addr, 0);
        chk("arst_pwdata", P_WData, 0);
        chk("arst_prw", P_RW, 0);
        chk("arst_cen", C_En, 0);
        step(); step();
        sRstN = 1;
        step();
        sDone = 2'b01; sRData0 = 32'h77;
        step(); chk("late_done_stall", Stall, 0); chk("late_done_odata", OData, 0);
        step(); chk("late_done_odata2", OData, 0); chk("late_no_start", P_Start, 0);
        idleStim();
        step();

        // Randomized traffic.
        repeat (3000) begin
            genRandom();
            step();
        end
        idleStim();
        for (int i = 0; i < 400 && mBusy; i++) begin
            step();
        end
        chk("drain_idle", 32'(mBusy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
